bram_vector_writer: RTL and testbench
=====================================

Name: bram_vector_writer

Overview:
- Write-side controller for the banked vector BRAM. That memory takes one word per write but returns PIPE_WIDTH words per read.
- This block accepts a whole PIPE_WIDTH-word vector plus a row index over a valid/ready handshake.
- It serialises the vector into PIPE_WIDTH single-word BRAM write cycles, with per-word write masking.
- It sits between the datapath/loader and the BRAM address, data_in, cs, we and oe pins.

Parameters:
- varWIDTH, 32, bits per word.
- ADD_WIDTH, 10, BRAM word-address width.
- PIPE_WIDTH, 16, words per vector. Must be a power of two and at least 2.
- Derived localparams: SEL_W = $clog2(PIPE_WIDTH); ROW_W = ADD_WIDTH - SEL_W.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  vector request valid.
- in_ready  output  1  block can accept a request.
- in_row  input  ROW_W  destination row.
- in_data  input  varWIDTH*PIPE_WIDTH  vector; word k occupies bits [(k+1)*varWIDTH-1 -: varWIDTH].
- in_mask  input  PIPE_WIDTH  bit k=1 writes word k.
- bram_add  output  ADD_WIDTH  BRAM address.
- bram_data_in  output  varWIDTH  BRAM write data.
- bram_cs  output  1  BRAM chip select.
- bram_we  output  1  BRAM write enable.
- bram_oe  output  PIPE_WIDTH  BRAM per-bank output enable.
- busy  output  1  high while a request is in progress.
- done  output  1  one-cycle pulse when a request completes.

Behaviour:
- Reset values (async, immediate): state IDLE; in_ready 0 while rst is high; bram_add, bram_data_in, bram_cs, bram_we, bram_oe, busy and done all 0. Latched row, data, mask and word counter are cleared.
- in_ready = (state==IDLE) && !rst.
- Accept: on an edge with in_valid && in_ready, latch in_row, in_data and in_mask; clear counter k=0; go to WRITE. No input is sampled outside acceptance.
- WRITE state, cycle k of 0..PIPE_WIDTH-1, registered outputs:
  - bram_cs=1, bram_we=mask[k]
  - bram_add={row,k[SEL_W-1:0]}, i.e. row*PIPE_WIDTH+k
  - bram_data_in=word k, bram_oe=0
  - busy=1
- Masked-out words still take their cycle with bram_we=0 and cs=1, so the BRAM sees a read with oe=0 and stays idle. Latency is fixed and mask-independent.
- Counter increments each WRITE cycle. After k=PIPE_WIDTH-1 the next state is IDLE, or RB_ISSUE if the optional feature is compiled in.
- Completion: done is a registered pulse high in the first cycle after the last bus cycle. In that same cycle state=IDLE, busy=0, in_ready=1, and bram_cs, bram_we and bram_add return to 0.
- Back-to-back: a request accepted in the done cycle starts WRITE at the next cycle. There is no idle gap beyond the done cycle.
- Request-to-done: PIPE_WIDTH+1 cycles after the accept edge.
- in_mask all zero: still runs PIPE_WIDTH cycles with we=0, then pulses done.
- in_valid held high while busy: ignored, no re-acceptance.
- rst asserted mid-request: outputs drop to 0 immediately and any partial writes stay in the BRAM. No done is produced, and the request is lost.
- Row field wraps naturally: row = 2^ROW_W-1, word PIPE_WIDTH-1 addresses 2^ADD_WIDTH-1.

Optional Feature:
- Macro: BRAM_VECTOR_WRITER_READBACK_CHECK_EN.
- Defined:
  - Adds ports bram_data_out (input, varWIDTH*PIPE_WIDTH) and check_err (output, 1, reset 0).
  - After WRITE the FSM enters RB_ISSUE for one cycle: bram_cs=1, bram_we=0, bram_add={row,0}, bram_oe=mask.
  - It then enters RB_CHECK for one cycle: compare bram_data_out to the latched data for every word with mask[k]=1, then go to IDLE.
  - check_err is set on any mismatch, holds until the next acceptance, and is cleared on acceptance.
  - done is delayed by 2 cycles, so request-to-done is PIPE_WIDTH+3.
- Undefined: no extra ports, states or latency.

Test Plan:
- PIPE_WIDTH=4, ADD_WIDTH=6, row=5, data words {0x11,0x22,0x33,0x44}, mask=4'hF -> four write cycles, addresses 20,21,22,23 carrying 0x11..0x44; done 5 cycles after accept; a BRAM readback of row 5 returns all four words.
- Same setup with mask=4'b0101 -> we high only at addresses 20 and 22; addresses 21 and 23 keep their old contents; done still arrives at 5 cycles.
- Two requests with in_valid held continuously (rows 1 and 2) -> second accept lands in the done cycle of the first; addresses 4..7 then 8..11 with no gap.
- rst pulsed during the cycle carrying address 21 -> bram_cs/bram_we drop to 0 asynchronously, no done pulse, in_ready=1 after rst falls; a fresh request completes normally.
- row=15, mask=4'hF -> last address 63; no overflow, and done pulses after the fourth write.
- With READBACK_CHECK_EN, corrupt bank 2 of the BRAM model -> check_err=1 at done (PIPE_WIDTH+3 = 7 cycles); the next clean request clears it.

Source files
------------

// File: rtl/bram_vector_writer.sv
// bram_vector_writer: write-side controller for the banked vector BRAM.
// Accepts a PIPE_WIDTH-word vector plus a row index over valid/ready. It then issues one
// single-word BRAM write cycle per word, with a per-word write mask.
// Optional post-write readback check is enabled by defining BRAM_VECTOR_WRITER_READBACK_CHECK_EN.
module bram_vector_writer #(
  parameter int unsigned varWIDTH   = 32,
  parameter int unsigned ADD_WIDTH  = 10,
  parameter int unsigned PIPE_WIDTH = 16,
  localparam int unsigned SEL_W = $clog2(PIPE_WIDTH),
  localparam int unsigned ROW_W = ADD_WIDTH - SEL_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROW_W-1:0]               in_row,
  input  logic [varWIDTH*PIPE_WIDTH-1:0] in_data,
  input  logic [PIPE_WIDTH-1:0]          in_mask,
  output logic [ADD_WIDTH-1:0]           bram_add,
  output logic [varWIDTH-1:0]            bram_data_in,
  output logic                           bram_cs,
  output logic                           bram_we,
  output logic [PIPE_WIDTH-1:0]          bram_oe,
  output logic                           busy,
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
  input  logic [varWIDTH*PIPE_WIDTH-1:0] bram_data_out,
  output logic                           check_err,
`endif
  output logic                           done
);

`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
  typedef enum logic [1:0] {StIdle, StWrite, StRbIssue, StRbCheck} state_e;
`else
  typedef enum logic [0:0] {StIdle, StWrite} state_e;
`endif

  state_e                         state_q, state_d;
  logic [SEL_W-1:0]               cnt_q, cnt_d;
  logic [ROW_W-1:0]               row_q, row_d;
  logic [varWIDTH*PIPE_WIDTH-1:0] data_q, data_d;
  logic [PIPE_WIDTH-1:0]          mask_q, mask_d;

  logic [ADD_WIDTH-1:0]  add_d;
  logic [varWIDTH-1:0]   wdata_d;
  logic                  cs_d, we_d, busy_d, done_d;
  logic [PIPE_WIDTH-1:0] oe_d;
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
  logic                  err_d;
`endif

  assign in_ready = (state_q == StIdle) && !rst;

  // Next-state and next bus values; bus outputs are registered so each word owns a full cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    data_d  = data_q;
    mask_d  = mask_q;
    add_d   = '0;
    wdata_d = '0;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    oe_d    = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
    err_d   = check_err;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          row_d   = in_row;
          data_d  = in_data;
          mask_d  = in_mask;
          cnt_d   = '0;
          state_d = StWrite;
          // Word 0 goes out straight from the request so the bus starts next cycle.
          cs_d    = 1'b1;
          we_d    = in_mask[0];
          add_d   = {in_row, {SEL_W{1'b0}}};
          wdata_d = in_data[varWIDTH-1:0];
          busy_d  = 1'b1;
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      StWrite: begin
        if (cnt_q == {SEL_W{1'b1}}) begin
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
          // Read the whole row back with every written bank enabled.
          state_d = StRbIssue;
          cs_d    = 1'b1;
          add_d   = {row_q, {SEL_W{1'b0}}};
          oe_d    = mask_q;
          busy_d  = 1'b1;
`else
          state_d = StIdle;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          cs_d    = 1'b1;
          we_d    = mask_q[cnt_d];
          add_d   = {row_q, cnt_d};
          wdata_d = data_q[varWIDTH*cnt_d +: varWIDTH];
          busy_d  = 1'b1;
        end
      end
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
      StRbIssue: begin
        state_d = StRbCheck;
        busy_d  = 1'b1;
      end
      StRbCheck: begin
        state_d = StIdle;
        done_d  = 1'b1;
        for (int unsigned k = 0; k < PIPE_WIDTH; k++) begin
          if (mask_q[k] &&
              (bram_data_out[varWIDTH*k +: varWIDTH] != data_q[varWIDTH*k +: varWIDTH])) begin
            err_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State, request latches and registered BRAM bus; reset drops everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      row_q        <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      bram_add     <= '0;
      bram_data_in <= '0;
      bram_cs      <= 1'b0;
      bram_we      <= 1'b0;
      bram_oe      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
      check_err    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      bram_add     <= add_d;
      bram_data_in <= wdata_d;
      bram_cs      <= cs_d;
      bram_we      <= we_d;
      bram_oe      <= oe_d;
      busy         <= busy_d;
      done         <= done_d;
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
      check_err    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_bram_vector_writer.sv
// Testbench for bram_vector_writer with PIPE_WIDTH=4, ADD_WIDTH=6.
// A BRAM model is written from the DUT bus and compared against a reference memory
// updated from each request at word level.
module tb_bram_vector_writer;
  localparam int unsigned W   = 32;
  localparam int unsigned AW  = 6;
  localparam int unsigned P   = 4;
  localparam int unsigned SEL = 2;
  localparam int unsigned RW  = AW - SEL;
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int LAT  = P + 1 + 2 * RB;
  localparam int TLEN = P + RB;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] in_row   = '0;
  logic [W*P-1:0] in_data = '0;
  logic [P-1:0]  in_mask  = '0;
  logic [AW-1:0] bram_add;
  logic [W-1:0]  bram_data_in;
  logic          bram_cs, bram_we;
  logic [P-1:0]  bram_oe;
  logic          busy, done;
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
  logic [W*P-1:0] bram_data_out = '0;
  logic           check_err;
  logic           corrupt = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem     [1<<AW] = '{default: '0};
  logic [W-1:0] ref_mem [1<<AW] = '{default: '0};

  int           cyc  = 0;
  int           tr_n = 0;
  logic [AW-1:0] tr_add [1024];
  logic          tr_we  [1024];
  logic [W-1:0]  tr_dat [1024];
  int            tr_t   [1024];

  bram_vector_writer #(
    .varWIDTH  (W),
    .ADD_WIDTH (AW),
    .PIPE_WIDTH(P)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_row       (in_row),
    .in_data      (in_data),
    .in_mask      (in_mask),
    .bram_add     (bram_add),
    .bram_data_in (bram_data_in),
    .bram_cs      (bram_cs),
    .bram_we      (bram_we),
    .bram_oe      (bram_oe),
    .busy         (busy),
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
    .bram_data_out(bram_data_out),
    .check_err    (check_err),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  // BRAM write port
  always @(posedge clk) begin
    if (bram_cs && bram_we) mem[bram_add] <= bram_data_in;
  end

`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
  // BRAM vector read port, optionally corrupting bank 2
  always @(posedge clk) begin
    if (bram_cs && !bram_we) begin
      for (int k = 0; k < P; k++) begin
        bram_data_out[k*W +: W] <= mem[{bram_add[AW-1:SEL], SEL'(k)}] ^
                                   ((corrupt && k == 2) ? 32'h1 : 32'h0);
      end
    end
  end
`endif

  // Bus trace of every chip-select cycle, sampled mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bram_cs && tr_n < 1024) begin
      tr_add[tr_n] <= bram_add;
      tr_we[tr_n]  <= bram_we;
      tr_dat[tr_n] <= bram_data_in;
      tr_t[tr_n]   <= cyc;
      tr_n         <= tr_n + 1;
    end
  end

  function automatic logic [W*P-1:0] pack4(input logic [W-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Drives one request, returns negedges from accept until done is seen, updates reference.
  task automatic send(input logic [RW-1:0] row, input logic [W*P-1:0] data,
                      input logic [P-1:0] mask, output int lat);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1; in_row = row; in_data = data; in_mask = mask;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_row   = RW'($urandom);
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_mask  = P'($urandom);
    lat = 1;
    while (!done && lat < 50) begin @(negedge clk); lat++; end
    for (int k = 0; k < P; k++) if (mask[k]) ref_mem[int'(row) * P + k] = data[k*W +: W];
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b0 || bram_cs !== 1'b0 || bram_we !== 1'b0 || bram_add !== '0 ||
        bram_data_in !== '0 || bram_oe !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b cs=%b we=%b add=%0d din=%h oe=%b busy=%b done=%b, all 0 required",
               in_ready, bram_cs, bram_we, bram_add, bram_data_in, bram_oe, busy, done);
    end
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
    checks++;
    if (check_err !== 1'b0) begin
      errors++; $display("FAIL reset_check_err: got %b, expected 0", check_err);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b busy=%b, expected ready=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int base, lat, bad;
    logic [W*P-1:0] d;
    d = pack4(32'h11, 32'h22, 32'h33, 32'h44);
    base = tr_n;
    send(4'd5, d, 4'hF, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d, expected %0d", lat, LAT); end
    checks++;
    if (tr_n - base !== TLEN) begin
      errors++; $display("FAIL basic_cycles: got %0d cs cycles, expected %0d", tr_n - base, TLEN);
    end
    for (int k = 0; k < P; k++) begin
      checks++;
      if (tr_add[base+k] !== AW'(20 + k) || tr_we[base+k] !== 1'b1 || tr_dat[base+k] !== d[k*W +: W]) begin
        errors++;
        $display("FAIL basic_word%0d: add=%0d we=%b data=%h, expected add=%0d we=1 data=%h",
                 k, tr_add[base+k], tr_we[base+k], tr_dat[base+k], 20 + k, d[k*W +: W]);
      end
    end
    checks++;
    if (mem[20] !== 32'h11 || mem[21] !== 32'h22 || mem[22] !== 32'h33 || mem[23] !== 32'h44) begin
      errors++;
      $display("FAIL basic_readback: row5 = %h %h %h %h, expected 11 22 33 44", mem[20], mem[21], mem[22], mem[23]);
    end
    bad = 0;
    for (int a = 0; a < (1 << AW); a++) if (mem[a] !== ref_mem[a]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_mem: %0d words differ, expected 0", bad); end
  endtask

  task automatic test_mask();
    int base, lat;
    logic [W*P-1:0] d;
    d = pack4(32'h55, 32'h66, 32'h77, 32'h88);
    base = tr_n;
    send(4'd5, d, 4'b0101, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL mask_latency: got %0d, expected %0d", lat, LAT); end
    for (int k = 0; k < P; k++) begin
      checks++;
      if (tr_add[base+k] !== AW'(20 + k) || tr_we[base+k] !== ((k % 2) == 0)) begin
        errors++;
        $display("FAIL mask_word%0d: add=%0d we=%b, expected add=%0d we=%b",
                 k, tr_add[base+k], tr_we[base+k], 20 + k, (k % 2) == 0);
      end
    end
    checks++;
    if (mem[20] !== 32'h55 || mem[21] !== 32'h22 || mem[22] !== 32'h77 || mem[23] !== 32'h44) begin
      errors++;
      $display("FAIL mask_mem: row5 = %h %h %h %h, expected 55 22 77 44", mem[20], mem[21], mem[22], mem[23]);
    end
  endtask

  task automatic test_wrap();
    int base, lat;
    logic [W*P-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    base = tr_n;
    send(4'd15, d, 4'hF, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL wrap_latency: got %0d, expected %0d", lat, LAT); end
    checks++;
    if (tr_add[base+P-1] !== AW'(63) || mem[63] !== d[(P-1)*W +: W]) begin
      errors++;
      $display("FAIL wrap_last: add=%0d mem63=%h, expected add=63 mem63=%h",
               tr_add[base+P-1], mem[63], d[(P-1)*W +: W]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      int base, lat, bad, wbad;
      logic [RW-1:0] row;
      logic [W*P-1:0] d;
      logic [P-1:0] m;
      row = RW'($urandom_range(0, 15));
      d   = {$urandom, $urandom, $urandom, $urandom};
      m   = P'($urandom);
      base = tr_n;
      send(row, d, m, lat);
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL rand%0d_latency: got %0d, expected %0d", r, lat, LAT); end
      wbad = 0;
      for (int k = 0; k < P; k++) begin
        if (tr_add[base+k] !== AW'(int'(row) * P + k) || tr_we[base+k] !== m[k] ||
            tr_dat[base+k] !== d[k*W +: W]) wbad++;
      end
      checks++;
      if (wbad != 0 || tr_n - base !== TLEN) begin
        errors++;
        $display("FAIL rand%0d_bus: %0d bad words, %0d cs cycles; expected 0 bad, %0d cycles",
                 r, wbad, tr_n - base, TLEN);
      end
      bad = 0;
      for (int a = 0; a < (1 << AW); a++) if (mem[a] !== ref_mem[a]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand%0d_mem: %0d words differ, expected 0", r, bad); end
    end
  endtask

  task automatic test_back_to_back();
    int base, lat1, lat2, bad;
    logic [W*P-1:0] d1, d2;
    logic [P-1:0] m2;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    m2 = P'($urandom);
    base = tr_n;
    @(negedge clk);
    in_valid = 1'b1; in_row = 4'd1; in_data = d1; in_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    // valid stays high; new request must wait for the done cycle
    in_row = 4'd2; in_data = d2; in_mask = m2;
    lat1 = 1;
    while (!done && lat1 < 50) begin @(negedge clk); lat1++; end
    checks++;
    if (lat1 !== LAT || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first: lat=%0d ready=%b, expected lat=%0d ready=1", lat1, in_ready, LAT);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat2 = 1;
    while (!done && lat2 < 50) begin @(negedge clk); lat2++; end
    checks++;
    if (lat2 !== LAT) begin errors++; $display("FAIL b2b_second_latency: got %0d, expected %0d", lat2, LAT); end
    for (int k = 0; k < P; k++) ref_mem[4 + k] = d1[k*W +: W];
    for (int k = 0; k < P; k++) if (m2[k]) ref_mem[8 + k] = d2[k*W +: W];
    checks++;
    if (tr_n - base !== 2 * TLEN) begin
      errors++; $display("FAIL b2b_cycles: got %0d cs cycles, expected %0d", tr_n - base, 2 * TLEN);
    end
    for (int k = 0; k < P; k++) begin
      checks++;
      if (tr_add[base+k] !== AW'(4 + k) || tr_add[base+TLEN+k] !== AW'(8 + k) ||
          tr_we[base+TLEN+k] !== m2[k]) begin
        errors++;
        $display("FAIL b2b_word%0d: adds=%0d,%0d we2=%b, expected %0d,%0d we2=%b",
                 k, tr_add[base+k], tr_add[base+TLEN+k], tr_we[base+TLEN+k], 4 + k, 8 + k, m2[k]);
      end
    end
    checks++;
    if (tr_t[base+TLEN] - tr_t[base+P-1] !== 2 + 2 * RB) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles between writes, expected %0d",
               tr_t[base+TLEN] - tr_t[base+P-1], 2 + 2 * RB);
    end
    bad = 0;
    for (int a = 0; a < (1 << AW); a++) if (mem[a] !== ref_mem[a]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_mem: %0d words differ, expected 0", bad); end
  endtask

  task automatic test_mid_reset();
    int lat, bad, dn;
    logic [W*P-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_pre_ready: got %b, expected 1", in_ready); end
    in_valid = 1'b1; in_row = 4'd5; in_data = d; in_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bram_add !== AW'(21) || bram_cs !== 1'b1) begin
      errors++; $display("FAIL rst_pre_add: add=%0d cs=%b, expected add=21 cs=1", bram_add, bram_cs);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bram_cs !== 1'b0 || bram_we !== 1'b0 || bram_add !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: cs=%b we=%b add=%0d busy=%b ready=%b, expected all 0",
               bram_cs, bram_we, bram_add, busy, in_ready);
    end
    ref_mem[20] = d[W-1:0];
    dn = 0;
    repeat (2) begin @(negedge clk); if (done) dn++; end
    rst = 1'b0;
    repeat (3) begin #1; if (done) dn++; @(negedge clk); end
    checks++;
    if (dn != 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_after: done seen %0d times, ready=%b, expected 0 and 1", dn, in_ready);
    end
    bad = 0;
    for (int a = 0; a < (1 << AW); a++) if (mem[a] !== ref_mem[a]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_partial_mem: %0d words differ, expected 0", bad); end
    send(4'd6, {$urandom, $urandom, $urandom, $urandom}, 4'hF, lat);
    bad = 0;
    for (int a = 0; a < (1 << AW); a++) if (mem[a] !== ref_mem[a]) bad++;
    checks++;
    if (lat !== LAT || bad != 0) begin
      errors++; $display("FAIL rst_fresh: lat=%0d bad=%0d, expected lat=%0d bad=0", lat, bad, LAT);
    end
  endtask

`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
  task automatic test_readback();
    int lat;
    corrupt = 1'b1;
    send(4'd3, {$urandom, $urandom, $urandom, $urandom}, 4'hF, lat);
    checks++;
    if (lat !== P + 3 || check_err !== 1'b1) begin
      errors++; $display("FAIL rb_corrupt: lat=%0d err=%b, expected lat=%0d err=1", lat, check_err, P + 3);
    end
    @(negedge clk);
    checks++;
    if (check_err !== 1'b1) begin errors++; $display("FAIL rb_hold: err=%b, expected 1", check_err); end
    corrupt = 1'b0;
    send(4'd3, {$urandom, $urandom, $urandom, $urandom}, 4'hF, lat);
    checks++;
    if (lat !== P + 3 || check_err !== 1'b0) begin
      errors++; $display("FAIL rb_clean: lat=%0d err=%b, expected lat=%0d err=0", lat, check_err, P + 3);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_wrap();
    test_random();
    test_back_to_back();
    test_mid_reset();
`ifdef BRAM_VECTOR_WRITER_READBACK_CHECK_EN
    test_readback();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
